// File: rtl/jam_cost_server.sv
// Cost-table server for a JAM assignment engine: loads an 8x8 cost table,
// holds the engine in reset, serves cost lookups and scores the engine's result.
module jam_cost_server #(
    parameter int END_CYCLE = 10000000,
    parameter int RST_HOLD  = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LD_VALID,
    input  logic [6:0]  LD_DATA,
    output logic        LD_READY,
    output logic        JAM_RST,
    input  logic [2:0]  W,
    input  logic [2:0]  J,
    output logic [6:0]  Cost,
    input  logic        Valid,
    input  logic [8:0]  MinCost,
    input  logic [3:0]  MatchCount,
    input  logic [8:0]  GOLD_MIN,
    input  logic [3:0]  GOLD_CNT,
    output logic        DONE,
    output logic        PASS,
    output logic        TIMEOUT,
    output logic [23:0] LAT_CYC,
    output logic [15:0] ACC_CNT,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_TOUT = 3'd4;

    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
    localparam logic [31:0] END_LAST  = 32'(END_CYCLE - 1);

    logic [2:0]  state;
    logic [5:0]  addr;
    logic [31:0] hold_cnt;
    logic [23:0] lat;
    logic [2:0]  w_s;
    logic [2:0]  j_s;
    logic [6:0]  cost_mem [64];
    logic        wj_change;
    logic        timeout_hit;
    logic        result_ok;

    assign LD_READY    = (state == S_LOAD);
    assign JAM_RST     = (state == S_LOAD) || (state == S_HOLD);
    assign fsm_state   = state;
    assign Cost        = cost_mem[{w_s, j_s}];
    assign wj_change   = ({W, J} != {w_s, j_s});
    // Widened compare so END_CYCLE beyond the 24-bit counter simply never times out.
    assign timeout_hit = ({8'd0, lat} == END_LAST);
    assign result_ok   = (MinCost == GOLD_MIN) && (MatchCount == GOLD_CNT);

    // Table storage is deliberately unreset; only LOAD-state handshakes write it.
    always_ff @(posedge CLK) begin
        if (RST_N && (state == S_LOAD) && LD_VALID) begin
            cost_mem[addr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            w_s <= 3'd0;
            j_s <= 3'd0;
        end else begin
            w_s <= W;
            j_s <= J;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= S_LOAD;
            addr     <= 6'd0;
            hold_cnt <= 32'd0;
            lat      <= 24'd0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            TIMEOUT  <= 1'b0;
            LAT_CYC  <= 24'd0;
            ACC_CNT  <= 16'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (LD_VALID) begin
                        addr <= addr + 6'd1;
                        if (addr == 6'd63) begin
                            state    <= S_HOLD;
                            hold_cnt <= 32'd0;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_RUN;
                        lat   <= 24'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (wj_change && (ACC_CNT != 16'hFFFF)) begin
                        ACC_CNT <= ACC_CNT + 16'd1;
                    end
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (Valid) begin
                        LAT_CYC <= lat;
                        PASS    <= result_ok;
                        DONE    <= 1'b1;
                        state   <= S_FIN;
                    end else if (timeout_hit) begin
                        TIMEOUT <= 1'b1;
                        DONE    <= 1'b1;
                        PASS    <= 1'b0;
                        state   <= S_TOUT;
                    end else if (lat != 24'hFFFFFF) begin
                        lat <= lat + 24'd1;
                    end
                end
                S_FIN, S_TOUT: begin
                    state <= state;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: one default instance and one with
// END_CYCLE=50, driven from shared stimulus and checked against a bench model.
module tb_jam_cost_server;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        LD_VALID = 1'b0;
    logic [6:0]  LD_DATA = 7'd0;
    logic [2:0]  W = 3'd0;
    logic [2:0]  J = 3'd0;
    logic        Valid = 1'b0;
    logic [8:0]  MinCost = 9'd0;
    logic [3:0]  MatchCount = 4'd0;
    logic [8:0]  GOLD_MIN = 9'd250;
    logic [3:0]  GOLD_CNT = 4'd2;

    logic        ld_ready_a, jam_rst_a, done_a, pass_a, timeout_a;
    logic [6:0]  cost_a;
    logic [23:0] lat_a;
    logic [15:0] acc_a;
    logic [2:0]  state_a;
    logic        ld_ready_t, jam_rst_t, done_t, pass_t, timeout_t;
    logic [6:0]  cost_t;
    logic [23:0] lat_t;
    logic [15:0] acc_t;
    logic [2:0]  state_t;

    always #5 CLK = ~CLK;

    jam_cost_server dut_a (
        .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
        .LD_READY(ld_ready_a), .JAM_RST(jam_rst_a), .W(W), .J(J), .Cost(cost_a),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .GOLD_MIN(GOLD_MIN), .GOLD_CNT(GOLD_CNT), .DONE(done_a), .PASS(pass_a),
        .TIMEOUT(timeout_a), .LAT_CYC(lat_a), .ACC_CNT(acc_a), .fsm_state(state_a)
    );

    jam_cost_server #(.END_CYCLE(50), .RST_HOLD(3)) dut_t (
        .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
        .LD_READY(ld_ready_t), .JAM_RST(jam_rst_t), .W(W), .J(J), .Cost(cost_t),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .GOLD_MIN(GOLD_MIN), .GOLD_CNT(GOLD_CNT), .DONE(done_t), .PASS(pass_t),
        .TIMEOUT(timeout_t), .LAT_CYC(lat_t), .ACC_CNT(acc_t), .fsm_state(state_t)
    );

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] cost;
    } lookup_t;

    lookup_t    vecs [8];
    logic [6:0] model [64];
    logic [6:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         rc = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input int sel, input string tag, input logic d, input logic p,
                             input logic t, input logic [23:0] l, input logic [15:0] acc);
        if (sel == 0) begin
            check({tag, ".done"}, 32'(done_a), 32'(d));
            check({tag, ".pass"}, 32'(pass_a), 32'(p));
            check({tag, ".timeout"}, 32'(timeout_a), 32'(t));
            check({tag, ".lat"}, 32'(lat_a), 32'(l));
            check({tag, ".acc"}, 32'(acc_a), 32'(acc));
        end else begin
            check({tag, ".done_t"}, 32'(done_t), 32'(d));
            check({tag, ".pass_t"}, 32'(pass_t), 32'(p));
            check({tag, ".timeout_t"}, 32'(timeout_t), 32'(t));
            check({tag, ".lat_t"}, 32'(lat_t), 32'(l));
            check({tag, ".acc_t"}, 32'(acc_t), 32'(acc));
        end
    endtask

    // W/J driven during reset must not reach the lookup registers.
    task automatic do_reset(input bit chk_cost, input string tag);
        RST_N = 1'b0; LD_VALID = 1'b0; Valid = 1'b0; W = 3'd3; J = 3'd4;
        step();
        check({tag, ".ld_ready"}, 32'(ld_ready_a), 32'd1);
        check({tag, ".jam_rst"}, 32'(jam_rst_a), 32'd1);
        check({tag, ".jam_rst_t"}, 32'(jam_rst_t), 32'd1);
        check_res(0, tag, 1'b0, 1'b0, 1'b0, 24'd0, 16'd0);
        check_res(1, tag, 1'b0, 1'b0, 1'b0, 24'd0, 16'd0);
        if (chk_cost) check({tag, ".cost"}, 32'(cost_a), 32'(model[0]));
        RST_N = 1'b1; W = 3'd0; J = 3'd0;
    endtask

    task automatic load(input bit rnd);
        int   hs = 0;
        int   guard = 0;
        logic v, rdy;
        for (int i = 0; i < 64; i++) model[i] = rnd ? 7'($urandom_range(0, 127)) : 7'(i);
        while (hs < 64 && guard < 1000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            LD_VALID = v;
            LD_DATA = v ? model[hs] : 7'($urandom_range(0, 127));
            rdy = ld_ready_a;
            step();
            guard++;
            if (v && rdy) hs++;
        end
        check("load.handshakes", 32'(hs), 32'd64);
        // Extra words and an early result are offered during HOLD; both must be dropped.
        LD_VALID = 1'b1; LD_DATA = 7'h55; Valid = 1'b1; MinCost = GOLD_MIN; MatchCount = GOLD_CNT;
        for (int c = 0; c < 3; c++) begin
            check("hold.jam_rst", 32'(jam_rst_a), 32'd1);
            check("hold.jam_rst_t", 32'(jam_rst_t), 32'd1);
            check("hold.ld_ready", 32'(ld_ready_a), 32'd0);
            step();
        end
        check("run.jam_rst", 32'(jam_rst_a), 32'd0);
        check("run.jam_rst_t", 32'(jam_rst_t), 32'd0);
        check("run.ld_ready", 32'(ld_ready_a), 32'd0);
        check("run.done", 32'(done_a), 32'd0);
        check("run.done_t", 32'(done_t), 32'd0);
        LD_VALID = 1'b0; Valid = 1'b0;
        rc = 0;
    endtask

    task automatic lookup(input logic [2:0] w, input logic [2:0] j, input logic [6:0] exp,
                          input string tag);
        logic [6:0] e;
        W = w; J = j;
        exp_q.push_back(exp);
        step();
        rc++;
        e = exp_q.pop_front();
        check(tag, 32'(cost_a), 32'(e));
        check({tag, "_t"}, 32'(cost_t), 32'(e));
    endtask

    task automatic advance(input int target);
        while (rc < target) begin
            step();
            rc++;
        end
    endtask

    task automatic fire(input logic [8:0] min_cost, input logic [3:0] cnt);
        Valid = 1'b1; MinCost = min_cost; MatchCount = cnt;
        step();
        rc++;
        Valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] a;
        vecs[0] = '{3'd5, 3'd3, 7'd43};
        vecs[1] = '{3'd0, 3'd0, 7'd0};
        vecs[2] = '{3'd7, 3'd7, 7'd63};
        vecs[3] = '{3'd0, 3'd7, 7'd7};
        vecs[4] = '{3'd7, 3'd0, 7'd56};
        vecs[5] = '{3'd1, 3'd2, 7'd10};
        vecs[6] = '{3'd1, 3'd2, 7'd10};
        vecs[7] = '{3'd6, 3'd5, 7'd53};

        // Identity table, lookups, result on the last allowed cycle of dut_t.
        step();
        do_reset(1'b0, "rst0");
        load(1'b0);
        for (int i = 0; i < 8; i++) lookup(vecs[i].w, vecs[i].j, vecs[i].cost, "vec.cost");
        check("vec.acc", 32'(acc_a), 32'd7);
        check("vec.acc_t", 32'(acc_t), 32'd7);
        advance(49);
        check("pre49.done_t", 32'(done_t), 32'd0);
        fire(9'd250, 4'd2);
        check_res(0, "s1", 1'b1, 1'b1, 1'b0, 24'd49, 16'd7);
        check_res(1, "s1", 1'b1, 1'b1, 1'b0, 24'd49, 16'd7);
        Valid = 1'b1; MinCost = 9'd0;
        lookup(3'd2, 3'd2, 7'd18, "fin.cost");
        Valid = 1'b0;
        check_res(0, "frozen", 1'b1, 1'b1, 1'b0, 24'd49, 16'd7);
        check_res(1, "frozen", 1'b1, 1'b1, 1'b0, 24'd49, 16'd7);

        // Random data with random LD_VALID; timeout on dut_t; result at cycle 1000 on dut_a.
        do_reset(1'b1, "rst1");
        load(1'b1);
        advance(49);
        check("pre_tout.done_t", 32'(done_t), 32'd0);
        step();
        rc++;
        check_res(1, "tout", 1'b1, 1'b0, 1'b1, 24'd0, 16'd0);
        check("tout.done_a", 32'(done_a), 32'd0);
        for (int i = 63; i >= 0; i--) begin
            a = 6'(i);
            lookup(a[5:3], a[2:0], model[i], "rnd.cost");
        end
        check("rnd.acc", 32'(acc_a), 32'd64);
        check("rnd.acc_t", 32'(acc_t), 32'd0);
        advance(1000);
        fire(9'd250, 4'd2);
        check_res(0, "lat1000", 1'b1, 1'b1, 1'b0, 24'd1000, 16'd64);
        check_res(1, "lat1000", 1'b1, 1'b0, 1'b1, 24'd0, 16'd0);

        // Mid-run reset, reload required, then a mismatching result.
        do_reset(1'b1, "rst2");
        load(1'b0);
        advance(5);
        do_reset(1'b1, "midrun");
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst.jam_rst", 32'(jam_rst_a), 32'd1);
            check("post_rst.ld_ready", 32'(ld_ready_a), 32'd1);
        end
        load(1'b0);
        lookup(3'd5, 3'd3, 7'd43, "s3.cost");
        advance(10);
        fire(9'd251, 4'd2);
        check_res(0, "s3", 1'b1, 1'b0, 1'b0, 24'd10, 16'd1);
        check_res(1, "s3", 1'b1, 1'b0, 1'b0, 24'd10, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
